// File: rtl/ofifo_collect.sv
// rtl/ofifo_collect.sv - per-column output FIFOs that release only complete, aligned col-wide vectors
// Optional sticky error flags are built when OFIFO_COLLECT_ERR_EN is defined.
module ofifo_collect #(
    parameter int col   = 8,
    parameter int bw    = 16,
    parameter int depth = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic [1:0]        o_err
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = (aw + 1)'(1);

    logic [col-1:0]    empty;
    logic [col-1:0]    full;
    logic [col*bw-1:0] head;
    logic              rd_ok;

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = ~(|full);
    assign rd_ok   = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        logic [bw-1:0] mem [depth];
        logic [aw:0]   wptr;
        logic [aw:0]   rptr;
        logic          wr_ok;

        assign wr_ok    = wr[i] && !full[i];
        assign empty[i] = (wptr == rptr);
        assign full[i]  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
        assign head[bw*i +: bw] = mem[rptr[aw-1:0]];

        // Storage is deliberately not reset; only the pointers define what is valid.
        always_ff @(posedge clk) begin
            if (wr_ok && !reset)
                mem[wptr[aw-1:0]] <= in[bw*i +: bw];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_ok)
                    wptr <= wptr + ptr_one;
                if (rd_ok)
                    rptr <= rptr + ptr_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            out <= '0;
        else if (rd_ok)
            out <= head;
    end

`ifdef OFIFO_COLLECT_ERR_EN
    logic [1:0] err;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 2'b00;
        end else begin
            if (|(wr & full))
                err[0] <= 1'b1;
            if (rd && !o_valid)
                err[1] <= 1'b1;
        end
    end

    assign o_err = err;
`else
    assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_ofifo_collect.sv
// tb/tb_ofifo_collect.sv - directed self-checking bench for ofifo_collect
module tb_ofifo_collect;
    localparam int col   = 8;
    localparam int bw    = 16;
    localparam int depth = 64;
    localparam int vw    = col * bw;

`ifdef OFIFO_COLLECT_ERR_EN
    localparam bit err_en = 1'b1;
`else
    localparam bit err_en = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [vw-1:0] in;
    logic [col-1:0] wr;
    logic          rd;
    logic [vw-1:0] out;
    logic          o_valid;
    logic          o_full;
    logic          o_ready;
    logic [1:0]    o_err;

    int vectors     = 0;
    int miscompares = 0;

    ofifo_collect #(.col(col), .bw(bw), .depth(depth)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [vw-1:0] obs, input logic [vw-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [vw-1:0] aligned_vec(input int k);
        logic [vw-1:0] v;
        for (int i = 0; i < col; i++)
            v[bw*i +: bw] = 16'((k << 8) | i);
        return v;
    endfunction

    function automatic logic [vw-1:0] fill_vec(input logic [bw-1:0] base);
        logic [vw-1:0] v;
        for (int i = 0; i < col; i++)
            v[bw*i +: bw] = base + 16'(i);
        return v;
    endfunction

    initial begin
        logic [vw-1:0] v;
        logic [vw-1:0] a;
        logic [vw-1:0] b;
        int            d [col];

        reset = 1'b1;
        in    = '0;
        wr    = '0;
        rd    = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("reset_out",     out,            '0);
        chk("reset_valid",   vw'(o_valid),   vw'(1'b0));
        chk("reset_full",    vw'(o_full),    vw'(1'b0));
        chk("reset_ready",   vw'(o_ready),   vw'(1'b1));
        chk("reset_err",     vw'(o_err),     vw'(2'b00));

        // Aligned traffic: three vectors in, three out
        for (int k = 0; k < 3; k++) begin
            in = aligned_vec(k);
            wr = '1;
            tick();
        end
        wr = '0;
        chk("aligned_valid", vw'(o_valid), vw'(1'b1));
        rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("aligned_out%0d", k), out, aligned_vec(k));
        end
        rd = 1'b0;
        chk("aligned_drained", vw'(o_valid), vw'(1'b0));

        // Skewed columns: column i writes i+1 on cycle i
        v = '0;
        for (int i = 0; i < col; i++) begin
            in = '0;
            in[bw*i +: bw] = 16'(i + 1);
            v[bw*i +: bw]  = 16'(i + 1);
            wr = col'(1) << i;
            tick();
            chk($sformatf("skew_valid%0d", i), vw'(o_valid), vw'(i == col - 1));
        end
        wr = '0;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("skew_out",   out,          v);
        chk("skew_empty", vw'(o_valid), vw'(1'b0));

        // Full/overflow on column 3
        wr = 8'h08;
        for (int j = 0; j <= depth; j++) begin
            in = '0;
            in[bw*3 +: bw] = 16'(j);
            tick();
            if (j == depth - 1) begin
                chk("full_flag",  vw'(o_full),  vw'(1'b1));
                chk("full_ready", vw'(o_ready), vw'(1'b0));
            end
        end
        wr = '0;
        chk("ovf_full",  vw'(o_full),  vw'(1'b1));
        chk("ovf_err",   vw'(o_err),   vw'(err_en ? 2'b01 : 2'b00));
        chk("ovf_valid", vw'(o_valid), vw'(1'b0));
        in = fill_vec(16'h0A00);
        wr = 8'hF7;
        tick();
        wr = '0;
        chk("ovf_fill_valid", vw'(o_valid), vw'(1'b1));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        v = fill_vec(16'h0A00);
        v[bw*3 +: bw] = 16'h0000;
        chk("ovf_out",   out,          v);
        chk("ovf_after_full",  vw'(o_full),  vw'(1'b0));
        chk("ovf_after_ready", vw'(o_ready), vw'(1'b1));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_err",   vw'(o_err),   vw'(2'b00));
        chk("rst2_valid", vw'(o_valid), vw'(1'b0));

        // Underflow: read on empty leaves out untouched
        a = fill_vec(16'h1100);
        in = a;
        wr = '1;
        tick();
        wr = '0;
        rd = 1'b1;
        tick();
        chk("uf_first", out, a);
        tick();
        rd = 1'b0;
        chk("uf_hold", out, a);
        chk("uf_err",  vw'(o_err), vw'(err_en ? 2'b10 : 2'b00));

        // Simultaneous read and write with one entry per column
        a = fill_vec(16'h2200);
        b = fill_vec(16'h3300);
        in = a;
        wr = '1;
        tick();
        in = b;
        rd = 1'b1;
        tick();
        wr = '0;
        rd = 1'b0;
        chk("sim_out",   out,          a);
        chk("sim_valid", vw'(o_valid), vw'(1'b1));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("sim_next",  out,          b);
        chk("sim_empty", vw'(o_valid), vw'(1'b0));

        // Wrap-around: 200 skewed write/read pairs
        for (int p = 0; p < 200; p++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < col; i++)
                d[i] = int'($urandom_range(0, 7));
            in = v;
            for (int t = 0; t < 8; t++) begin
                for (int i = 0; i < col; i++)
                    wr[i] = (d[i] == t);
                tick();
            end
            wr = '0;
            chk($sformatf("wrap_valid%0d", p), vw'(o_valid), vw'(1'b1));
            rd = 1'b1;
            tick();
            rd = 1'b0;
            chk($sformatf("wrap_out%0d", p), out, v);
        end
        chk("wrap_empty", vw'(o_valid), vw'(1'b0));

        // Mid-operation reset with ten vectors buffered
        for (int k = 0; k < 10; k++) begin
            in = fill_vec(16'(16'h4000 + (k << 4)));
            wr = '1;
            tick();
        end
        chk("mrst_pre_valid", vw'(o_valid), vw'(1'b1));
        in = fill_vec(16'hDEAD);
        reset = 1'b1;
        rd = 1'b1;
        tick();
        reset = 1'b0;
        wr = '0;
        rd = 1'b0;
        chk("mrst_valid", vw'(o_valid), vw'(1'b0));
        chk("mrst_out",   out,          '0);
        a = fill_vec(16'h5500);
        in = a;
        wr = '1;
        tick();
        wr = '0;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("mrst_read",  out,          a);
        chk("mrst_empty", vw'(o_valid), vw'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ofifo_collect.md
# ofifo_collect

Output-side buffer for the MAC array: the counterpart of the L0 input bank. L0 accepts whole row vectors and releases them one row at a time. This block does the reverse. It accepts per-column results from the array's bottom edge, which arrive skewed in time with an independent write-valid per column. It releases a complete `col`-wide vector only when every column holds at least one entry, so downstream accumulation/SRAM write-back always sees aligned vectors.

## Interface
Parameters:
- `col`, 8, number of column FIFOs (array width)
- `bw`, 16, bits per column entry (psum width)
- `depth`, 64, entries per column FIFO (power of two)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `in`  in  col*bw  column i data on `in[bw*(i+1)-1:bw*i]`
- `wr`  in  col  per-column write strobe
- `rd`  in  1  pop one aligned vector
- `out`  out  col*bw  registered popped vector, same column packing as `in`
- `o_valid`  out  1  every column non-empty (vector available)
- `o_full`  out  1  at least one column full
- `o_ready`  out  1  no column full (all columns can accept)
- `o_err`  out  2  sticky errors {underflow, overflow}; see Configuration

## Operation
- Each column has storage `depth` x `bw`, write pointer and read pointer of log2(depth)+1 bits (wrap bit + index).
- empty[i]: pointers equal. full[i]: indices equal, wrap bits differ.
- Write: if `wr[i]` && !full[i] (pre-edge), store `in` slice at wptr[i], wptr[i]++. If full[i], the write is dropped and no pointer changes.
- Full is evaluated pre-edge. A write to a full column is dropped even if a read is accepted in the same cycle.
- Read accepted iff `rd` && `o_valid`:
  - all rptr[i]++ together
  - `out` <= head entry of every column
- `rd` with `o_valid` low: ignored. No pointer change, `out` holds.
- Simultaneous accepted read and write on the same non-full column: both occur, occupancy unchanged.
- Pointers wrap naturally modulo 2*depth. No special case at the index wrap.
- `o_valid` = &(~empty); `o_full` = |full; `o_ready` = ~(|full). All three are combinational from the pointers.
- Reset:
  - all pointers 0
  - `out` = 0, `o_err` = 0
  - hence `o_valid`=0, `o_full`=0, `o_ready`=1
  - Storage contents are not cleared.
- Reset mid-operation: all buffered data is discarded; same-cycle `wr`/`rd` are ignored.

## Timing
- Write-to-valid: 1 cycle. `o_valid` rises the cycle after the edge that writes the last empty column.
- Read latency: 1 cycle. `out` carries the popped vector from the edge that accepts `rd` and holds until the next accepted read.
- `o_valid` may fall in the same cycle `out` updates, if any column becomes empty.
- Back-to-back reads every cycle are sustained while `o_valid` stays high.
- Full flag: `o_full` rises the cycle after the depth-th unread write to any column.

## Configuration
- `OFIFO_COLLECT_ERR_EN` defined:
  - `o_err[0]` sets on any dropped write (`wr[i]` while full[i]).
  - `o_err[1]` sets on `rd` while `o_valid`=0.
  - Both are sticky and cleared only by `reset`.
- Undefined: `o_err` is tied to 2'b00 and the error logic is absent. The port is always present, so the bench is unchanged.

## Test plan
- Reset check: assert `reset` 2 cycles -> `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, `o_err`=0.
- Aligned traffic:
  - Stimulus: write all columns together with vectors V0..V2 (col i of Vk = 16'h0k0i), then 3 reads.
  - Required: `out` = V0, V1, V2 in order; `o_valid`=0 after the third read.
- Skewed columns:
  - Stimulus: column i writes value i+1 at cycle i, i=0..7.
  - Required: `o_valid` stays 0 until the cycle after column 7's write. A read then gives `out` slice i = i+1.
- Full/overflow:
  - Stimulus: write column 3 only, 65 times (values 0..64).
  - Required: `o_full`=1 and `o_ready`=0 after the 64th write. The 65th write is dropped; with the macro, `o_err`=2'b01.
  - Then fill the other columns once and read 1 -> column 3 slice = 0.
- Underflow and simultaneous events:
  - Stimulus: `rd` while empty.
  - Required: `out` unchanged; with the macro, `o_err[1]`=1.
  - Stimulus: with 1 entry in every column, `rd` plus `wr`=all-ones in the same cycle.
  - Required: `o_valid` stays 1 and the next read returns the new vector.
- Wrap-around and mid-reset:
  - Stimulus: 200 write/read pairs with a random `wr` skew of 0..7 cycles.
  - Required: data matches the scoreboard across pointer wrap.
  - Stimulus: assert `reset` with 10 entries buffered.
  - Required: `o_valid`=0 the next cycle, and the next vector read is data written after reset.
